uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single UART transmitter among NUM_REQ byte sources. It accepts one byte at a time from each requester, drives the UART TX handshake (Tx_valid, input_tx, PF, Tx_err, sel), and tracks ready through accept and completion. Multi-byte packets hold the grant until their last byte. It sits directly in front of the UART module, in the same clock domain.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// Holds the arbiter state encoding and reset constants.
package uart_pkg;

  localparam int         WIDTH_SIZE_DEF = 8;
  localparam logic [1:0] SEL_RESET      = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DONE
  } tx_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin select over a masked request vector.
// The search begins one slot after last_grant and wraps.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      winner,
  output logic               found
);

  always_comb begin
    int          idx;
    logic [IW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_grant) + k) % NUM_REQ;
      cand = IW'(idx);
      if (!found && req[cand] && mask[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ sources.
// Packets keep the grant until their last byte; accept has a timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int WIDTH_SIZE     = WIDTH_SIZE_DEF,
  parameter  int NUM_REQ        = 4,
  parameter  int ACCEPT_TIMEOUT = 16,
  localparam int IW             = $clog2(NUM_REQ),
  localparam int CW             = $clog2(ACCEPT_TIMEOUT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*WIDTH_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_pf,
  input  logic [NUM_REQ-1:0]            req_err,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic [1:0]                    cfg_sel,
  output logic                          Tx_valid,
  output logic [WIDTH_SIZE-1:0]         input_tx,
  output logic                          PF,
  output logic                          Tx_err,
  output logic [1:0]                    sel,
  input  logic                          ready,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  tx_arb_state_t      state, state_n;
  logic [IW-1:0]      last_grant;
  logic               lock;
  logic               last_q;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0]      winner;
  logic               found;
  logic               grant;
  logic               to_fire;

  // A held lock narrows eligibility to the packet owner only.
  assign owner_oh = NUM_REQ'(1) << grant_id;
  assign elig     = lock ? owner_oh : '1;

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req       (req_valid),
    .mask      (elig),
    .last_grant(last_grant),
    .winner    (winner),
    .found     (found)
  );

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    to_fire = 1'b0;
    cnt_nx  = cnt + 1'b1;
    unique case (state)
      IDLE: begin
        if (ready && found) begin
          grant   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT_ACCEPT;
      WAIT_ACCEPT: begin
        if (!ready) begin
          state_n = WAIT_DONE;
        end else if (cnt_nx == CW'(ACCEPT_TIMEOUT - 1)) begin
          to_fire = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_DONE: begin
        if (ready) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= IW'(NUM_REQ - 1);
      lock        <= 1'b0;
      last_q      <= 1'b0;
      cnt         <= '0;
      input_tx    <= '0;
      PF          <= 1'b0;
      Tx_err      <= 1'b0;
      sel         <= SEL_RESET;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      timeout_err <= to_fire;
      if (grant) begin
        input_tx   <= req_data[int'(winner)*WIDTH_SIZE +: WIDTH_SIZE];
        PF         <= req_pf[winner];
        Tx_err     <= req_err[winner];
        last_q     <= req_last[winner];
        grant_id   <= winner;
        last_grant <= winner;
      end
      if (state == IDLE && !lock) sel <= cfg_sel;
      if (state == ISSUE) begin
        lock <= !last_q;
        cnt  <= '0;
      end else if (to_fire) begin
        lock <= 1'b0;
      end
      if (state == WAIT_ACCEPT && ready) cnt <= cnt_nx;
    end
  end

  assign Tx_valid = (state == ISSUE);
  assign req_ack  = (state == ISSUE) ? owner_oh : '0;
  assign busy     = (state != IDLE) || lock;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_uart_tx_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int AT = 16;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_pf, req_err, req_last, req_ack;
  logic [N*W-1:0] req_data;
  logic [1:0]     cfg_sel, sel;
  logic           Tx_valid, PF, Tx_err, ready, busy, timeout_err;
  logic [W-1:0]   input_tx;
  logic [IW-1:0]  grant_id;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .WIDTH_SIZE(W), .NUM_REQ(N), .ACCEPT_TIMEOUT(AT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_pf(req_pf), .req_err(req_err), .req_last(req_last),
    .req_ack(req_ack), .cfg_sel(cfg_sel),
    .Tx_valid(Tx_valid), .input_tx(input_tx),
    .PF(PF), .Tx_err(Tx_err), .sel(sel), .ready(ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  // inputs as sampled by the coming edge
  logic [N-1:0]   p_valid, p_pf, p_err, p_last;
  logic [N*W-1:0] p_data;
  logic           p_ready;
  logic [1:0]     p_cfg;

  // model: free = arbiter can take a new byte; k = edges since grant
  bit           m_free, m_lock, m_seen_low, m_lastq, m_tv, m_to;
  int           m_k, m_last, m_owner, m_gid;
  logic [W-1:0] m_tx;
  bit           m_pf, m_err;
  logic [1:0]   m_sel;

  // stimulus controls
  bit     req_auto, rand_idle, u_manual;
  logic [N-1:0] keep;
  int     u_ign_pct, u_delay, u_low;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_free = 1; m_lock = 0; m_seen_low = 0; m_lastq = 0;
    m_tv = 0; m_to = 0; m_k = 0;
    m_last = N - 1; m_owner = 0; m_gid = 0;
    m_tx = '0; m_pf = 0; m_err = 0; m_sel = 2'b00;
  endtask

  task automatic model_edge();
    bit free0, lock0;
    int w;
    free0 = m_free;
    lock0 = m_lock;
    w = -1;
    m_tv = 0;
    m_to = 0;
    if (free0 && !lock0) m_sel = p_cfg;
    if (free0) begin
      if (p_ready) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (w < 0 && p_valid[c] && (!lock0 || c == m_owner)) w = c;
        end
      end
      if (w >= 0) begin
        m_free = 0; m_k = 0; m_seen_low = 0;
        m_last = w; m_owner = w; m_gid = w;
        m_tx = p_data[w*W +: W];
        m_pf = p_pf[w]; m_err = p_err[w]; m_lastq = p_last[w];
        m_tv = 1;
      end
    end else begin
      m_k++;
      if (m_k == 1) m_lock = !m_lastq;
      else if (m_seen_low) begin
        if (p_ready) m_free = 1;
      end else if (!p_ready) m_seen_low = 1;
      else if (m_k == AT) begin
        m_free = 1; m_lock = 0; m_to = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e_ack;
    e_ack = '0;
    if (m_tv) e_ack[m_gid] = 1'b1;
    chk("Tx_valid", Tx_valid, m_tv);
    chk("req_ack", req_ack, e_ack);
    chk("timeout_err", timeout_err, m_to);
    chk("busy", busy, !m_free || m_lock);
    chk("sel", sel, m_sel);
    chk("grant_id", grant_id, m_gid);
    chk("input_tx", input_tx, m_tx);
    chk("PF", PF, m_pf);
    chk("Tx_err", Tx_err, m_err);
  endtask

  task automatic present(input int i, input logic [7:0] d,
                         input logic l, input logic p, input logic e);
    req_valid[i]       = 1'b1;
    req_data[i*W +: W] = d;
    req_last[i]        = l;
    req_pf[i]          = p;
    req_err[i]         = e;
  endtask

  task automatic react();
    for (int i = 0; i < N; i++) begin
      if (req_ack[i] && !keep[i]) req_valid[i] = 1'b0;
      if (req_auto && !req_valid[i] && $urandom_range(0, 2) == 0)
        present(i, 8'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom));
    end
    if (!u_manual) begin
      if (Tx_valid && $urandom_range(0, 99) >= u_ign_pct)
        u_delay = $urandom_range(0, 3);
      if (u_low > 0) begin
        u_low--;
        if (u_low == 0) ready = 1'b1;
      end else if (u_delay == 0) begin
        ready = 1'b0;
        u_low = $urandom_range(1, 5);
        u_delay = -1;
      end else if (u_delay > 0) begin
        u_delay--;
      end else if (rand_idle && $urandom_range(0, 9) == 0) begin
        ready = 1'b0;
        u_low = 1;
      end
    end
  endtask

  task automatic tick();
    p_valid = req_valid; p_data = req_data; p_pf = req_pf;
    p_err = req_err; p_last = req_last; p_ready = ready;
    p_cfg = cfg_sel;
    @(negedge clk);
    cyc++;
    model_edge();
    compare_all();
    react();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0; keep = '0;
    ready = 1'b1; u_delay = -1; u_low = 0; u_manual = 0;
    #1;
    chk("rst_Tx_valid", Tx_valid, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_input_tx", input_tx, 0);
    chk("rst_PF", PF, 0);
    chk("rst_Tx_err", Tx_err, 0);
    chk("rst_sel", sel, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_until_tv(input string nm, input int bound);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!Tx_valid && n < bound);
    if (!Tx_valid) chk(nm, Tx_valid, 1);
  endtask

  task automatic wait_idle(input string nm, input int bound);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < bound);
    if (busy) chk(nm, busy, 0);
  endtask

  initial begin
    int n, extra, t0, r1_n, gap;
    int gq[$];
    logic [7:0] dq[$];
    int eg5[5] = '{0, 1, 2, 3, 0};
    int eg4[4] = '{1, 1, 1, 2};
    logic [7:0] ed4[4] = '{8'hB0, 8'hB1, 8'hB2, 8'hC0};

    reset = 1'b0;
    req_valid = '0; req_data = '0; req_pf = '0; req_err = '0;
    req_last = '0; cfg_sel = 2'b00; ready = 1'b1;
    req_auto = 0; rand_idle = 0; u_ign_pct = 0; keep = '0;
    u_delay = -1; u_low = 0; u_manual = 0;
    #2;
    do_reset();

    // single byte
    present(0, 8'hA5, 1'b1, 1'b1, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!Tx_valid && n < 10);
    chk("t1_latency", n, 1);
    chk("t1_data", input_tx, 8'hA5);
    chk("t1_pf", PF, 1);
    chk("t1_ack", req_ack, 4'b0001);
    extra = 0;
    n = 0;
    do begin
      tick(); n++;
      if (Tx_valid) extra++;
    end while (busy && n < 30);
    chk("t1_busy_drop", busy, 0);
    chk("t1_single_pulse", extra, 0);

    // fairness
    do_reset();
    for (int i = 0; i < N; i++) present(i, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0);
    keep = '1;
    n = 0;
    while (gq.size() < 5 && n < 200) begin
      tick(); n++;
      if (Tx_valid) begin gq.push_back(int'(grant_id)); dq.push_back(input_tx); end
    end
    chk("t2_count", gq.size(), 5);
    for (int k = 0; k < gq.size() && k < 5; k++) begin
      chk("t2_order", gq[k], eg5[k]);
      chk("t2_data", dq[k], 8'(8'h10 + eg5[k]));
    end

    // packet lock with a gapped owner
    do_reset();
    gq.delete(); dq.delete();
    present(1, 8'hB0, 1'b0, 1'b0, 1'b0);
    present(2, 8'hC0, 1'b1, 1'b0, 1'b0);
    r1_n = 1; gap = 0; n = 0;
    while (gq.size() < 4 && n < 300) begin
      tick(); n++;
      if (Tx_valid) begin gq.push_back(int'(grant_id)); dq.push_back(input_tx); end
      if (!req_valid[1] && r1_n < 3) begin
        gap++;
        if (gap >= 8) begin
          present(1, 8'(8'hB0 + r1_n), 1'(r1_n == 2), 1'b0, 1'b0);
          r1_n++; gap = 0;
        end
      end
    end
    chk("t3_count", gq.size(), 4);
    for (int k = 0; k < gq.size() && k < 4; k++) begin
      chk("t3_owner", gq[k], eg4[k]);
      chk("t3_data", dq[k], ed4[k]);
    end
    wait_idle("t3_idle", 40);

    // accept timeout
    do_reset();
    u_ign_pct = 100;
    present(0, 8'h40, 1'b0, 1'b0, 1'b0);
    present(1, 8'h41, 1'b1, 1'b0, 1'b0);
    run_until_tv("t4_first_tv", 10);
    t0 = cyc; n = 0;
    do begin tick(); n++; end while (!timeout_err && n < 40);
    chk("t4_timeout_dist", cyc - t0, 16);
    run_until_tv("t4_next_tv", 10);
    chk("t4_next_owner", grant_id, 1);
    u_ign_pct = 0;
    wait_idle("t4_idle", 40);

    // sel holds through a packet
    do_reset();
    present(3, 8'h77, 1'b0, 1'b0, 1'b0);
    run_until_tv("t5_first_tv", 10);
    cfg_sel = 2'b11;
    gap = 0; n = 0;
    do begin
      tick(); n++;
      if (!req_valid[3] && gap >= 0) begin
        gap++;
        if (gap >= 4) begin present(3, 8'h78, 1'b1, 1'b0, 1'b0); gap = -1; end
      end
    end while (!Tx_valid && n < 60);
    chk("t5_second_tv", Tx_valid, 1);
    chk("t5_sel_mid", sel, 0);
    wait_idle("t5_idle", 40);
    chk("t5_sel_at_idle", sel, 0);
    tick();
    chk("t5_sel_after", sel, 2'b11);
    cfg_sel = 2'b00;

    // reset while waiting for UART completion
    do_reset();
    u_manual = 1;
    present(2, 8'h22, 1'b1, 1'b0, 1'b0);
    run_until_tv("t6_first_tv", 10);
    ready = 1'b0;
    tick();
    tick();
    present(0, 8'h5A, 1'b1, 1'b0, 1'b0);
    present(3, 8'h33, 1'b1, 1'b0, 1'b0);
    tick();
    chk("t6_busy_before", busy, 1);
    do_reset();
    present(0, 8'h5A, 1'b1, 1'b0, 1'b0);
    present(3, 8'h33, 1'b1, 1'b0, 1'b0);
    run_until_tv("t6_after_tv", 10);
    chk("t6_first_owner", grant_id, 0);
    chk("t6_first_data", input_tx, 8'h5A);
    wait_idle("t6_idle", 40);

    // random traffic
    do_reset();
    req_auto = 1; rand_idle = 1; u_ign_pct = 10;
    repeat (3000) begin
      tick();
      if ($urandom_range(0, 7) == 0) cfg_sel = 2'($urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
